// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types and encodings for the 8-bit MCU control unit.
// Contents: opcode enum, FSM state enum, acc_src / alu_op encodings and
// the is_two_byte() helper used by the decoder.
package mcu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_LDA = 4'h2,
        OP_STA = 4'h3,
        OP_ADD = 4'h4,
        OP_SUB = 4'h5,
        OP_IN  = 4'h6,
        OP_OUT = 4'h7,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_OPFETCH = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEMRD   = 3'd4,
        ST_MEMWR   = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    localparam logic [1:0] ACC_SRC_MEM = 2'd0;
    localparam logic [1:0] ACC_SRC_IMM = 2'd1;
    localparam logic [1:0] ACC_SRC_ALU = 2'd2;
    localparam logic [1:0] ACC_SRC_IN  = 2'd3;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Instructions carrying an operand byte after the opcode byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        logic res;
        case (op)
            OP_LDI, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_JMP, OP_JZ: res = 1'b1;
            default:                                               res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mcu_ctrl_decode.sv
// mcu_ctrl_decode: combinational opcode class decode.
// Ports:
//   op_i        opcode (IR[7:4])
//   two_byte_o  instruction has an operand byte
//   mem_rd_o    instruction reads data memory (LDA/ADD/SUB)
//   mem_wr_o    instruction writes data memory (STA)
//   legal_o     opcode is defined (0x0-0x9, 0xF)
module mcu_ctrl_decode
    import mcu_pkg::*;
(
    input  logic [3:0] op_i,
    output logic       two_byte_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       legal_o
);

    // Class decode of the opcode field.
    always_comb begin
        two_byte_o = is_two_byte(op_i);
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        legal_o    = 1'b1;
        case (op_i)
            OP_LDA, OP_ADD, OP_SUB: mem_rd_o = 1'b1;
            OP_STA:                 mem_wr_o = 1'b1;
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: legal_o = 1'b0;
            default: begin
                mem_rd_o = 1'b0;
                mem_wr_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mcu_ctrl.sv
// mcu_ctrl: multi-cycle sequencer for the 8-bit MCU core.
// Ports:
//   clk, resetb        clock (rising edge), async active-low reset
//   ir_op              current opcode from IR[7:4]
//   zero               ACC==0 flag
//   mem_ack            memory handshake acknowledge
//   mem_req/mem_we     memory request / write enable
//   addr_sel           memory address source: 0=PC, 1=MAR
//   ir_ld, pc_inc, pc_ld, mar_ld, acc_ld, out_ld   datapath strobes
//   acc_src, alu_op    ACC input select / ALU operation
//   retire, halted, illegal   status
// Only the state register is sequential; every output is decoded from the
// state, opcode, zero flag and ack, and is gated by resetb so that nothing
// reaches the datapath while reset is held.
module mcu_ctrl
    import mcu_pkg::*;
(
    input  logic       clk,
    input  logic       resetb,
    input  logic [3:0] ir_op,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       mar_ld,
    output logic       acc_ld,
    output logic       out_ld,
    output logic [1:0] acc_src,
    output logic       alu_op,
    output logic       retire,
    output logic       halted,
    output logic       illegal
);

    state_e state_q, state_d;

    logic two_byte_s, mem_rd_s, mem_wr_s, legal_s;

    logic       mem_req_s, mem_we_s, addr_sel_s;
    logic       ir_ld_s, pc_inc_s, pc_ld_s, mar_ld_s, acc_ld_s, out_ld_s;
    logic [1:0] acc_src_s;
    logic       alu_op_s, retire_s, halted_s, illegal_s;

    mcu_ctrl_decode u_decode (
        .op_i       (ir_op),
        .two_byte_o (two_byte_s),
        .mem_rd_o   (mem_rd_s),
        .mem_wr_o   (mem_wr_s),
        .legal_o    (legal_s)
    );

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        addr_sel_s = 1'b0;
        ir_ld_s    = 1'b0;
        pc_inc_s   = 1'b0;
        pc_ld_s    = 1'b0;
        mar_ld_s   = 1'b0;
        acc_ld_s   = 1'b0;
        out_ld_s   = 1'b0;
        acc_src_s  = ACC_SRC_MEM;
        alu_op_s   = ALU_ADD;
        retire_s   = 1'b0;
        halted_s   = 1'b0;
        illegal_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ack) begin
                    ir_ld_s  = 1'b1;
                    pc_inc_s = 1'b1;
                    state_d  = ST_DECODE;
                end else begin
                    state_d  = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // HLT retires here; it never visits EXEC.
                illegal_s = ~legal_s;
                if (ir_op == OP_HLT) begin
                    retire_s = 1'b1;
                    state_d  = ST_HALT;
                end else if (two_byte_s) begin
                    state_d  = ST_OPFETCH;
                end else begin
                    state_d  = ST_EXEC;
                end
            end
            ST_OPFETCH: begin
                mem_req_s = 1'b1;
                if (mem_ack) begin
                    mar_ld_s = 1'b1;
                    pc_inc_s = 1'b1;
                    if (mem_rd_s) begin
                        state_d = ST_MEMRD;
                    end else if (mem_wr_s) begin
                        state_d = ST_MEMWR;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_OPFETCH;
                end
            end
            ST_EXEC: begin
                retire_s = 1'b1;
                state_d  = ST_FETCH;
                case (ir_op)
                    OP_LDI: begin
                        acc_ld_s  = 1'b1;
                        acc_src_s = ACC_SRC_IMM;
                    end
                    OP_IN: begin
                        acc_ld_s  = 1'b1;
                        acc_src_s = ACC_SRC_IN;
                    end
                    OP_OUT: out_ld_s = 1'b1;
                    OP_JMP: pc_ld_s  = 1'b1;
                    OP_JZ:  pc_ld_s  = zero;
                    default: begin
                        acc_ld_s = 1'b0;
                    end
                endcase
            end
            ST_MEMRD: begin
                mem_req_s  = 1'b1;
                addr_sel_s = 1'b1;
                if (mem_ack) begin
                    acc_ld_s = 1'b1;
                    retire_s = 1'b1;
                    state_d  = ST_FETCH;
                    if (ir_op == OP_LDA) begin
                        acc_src_s = ACC_SRC_MEM;
                    end else begin
                        acc_src_s = ACC_SRC_ALU;
                        alu_op_s  = (ir_op == OP_SUB) ? ALU_SUB : ALU_ADD;
                    end
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMWR: begin
                mem_req_s  = 1'b1;
                mem_we_s   = 1'b1;
                addr_sel_s = 1'b1;
                if (mem_ack) begin
                    retire_s = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d  = ST_MEMWR;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
                state_d  = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset gating: outputs drop immediately when resetb falls mid-access.
    assign mem_req  = resetb & mem_req_s;
    assign mem_we   = resetb & mem_we_s;
    assign addr_sel = resetb & addr_sel_s;
    assign ir_ld    = resetb & ir_ld_s;
    assign pc_inc   = resetb & pc_inc_s;
    assign pc_ld    = resetb & pc_ld_s;
    assign mar_ld   = resetb & mar_ld_s;
    assign acc_ld   = resetb & acc_ld_s;
    assign out_ld   = resetb & out_ld_s;
    assign acc_src  = {2{resetb}} & acc_src_s;
    assign alu_op   = resetb & alu_op_s;
    assign retire   = resetb & retire_s;
    assign halted   = resetb & halted_s;
    assign illegal  = resetb & illegal_s;

endmodule

// File: tb/tb_mcu_ctrl.sv
// tb_mcu_ctrl: self-checking bench for mcu_ctrl. A per-instruction
// reference builds the expected strobe vector of every cycle from the
// instruction's phases (fetch, decode, operand fetch, execute / memory
// access) and the memory wait counts chosen for it.
module tb_mcu_ctrl;

    logic       clk = 1'b0;
    logic       resetb;
    logic [3:0] ir_op;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, mar_ld;
    logic       acc_ld, out_ld, alu_op, retire, halted, illegal;
    logic [1:0] acc_src;

    int total = 0;
    int bad   = 0;

    // Bit masks of the observation vector.
    localparam logic [14:0] REQ  = 15'h4000;
    localparam logic [14:0] WE   = 15'h2000;
    localparam logic [14:0] AS   = 15'h1000;
    localparam logic [14:0] IRL  = 15'h0800;
    localparam logic [14:0] PINC = 15'h0400;
    localparam logic [14:0] PLD  = 15'h0200;
    localparam logic [14:0] MAR  = 15'h0100;
    localparam logic [14:0] ACC  = 15'h0080;
    localparam logic [14:0] OUTL = 15'h0040;
    localparam logic [14:0] SRC1 = 15'h0010;
    localparam logic [14:0] SRC2 = 15'h0020;
    localparam logic [14:0] SRC3 = 15'h0030;
    localparam logic [14:0] ALUS = 15'h0008;
    localparam logic [14:0] RET  = 15'h0004;
    localparam logic [14:0] HLT  = 15'h0002;
    localparam logic [14:0] ILL  = 15'h0001;

    logic [14:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, mar_ld,
                  acc_ld, out_ld, acc_src, alu_op, retire, halted, illegal};

    mcu_ctrl dut (
        .clk      (clk),
        .resetb   (resetb),
        .ir_op    (ir_op),
        .zero     (zero),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .addr_sel (addr_sel),
        .ir_ld    (ir_ld),
        .pc_inc   (pc_inc),
        .pc_ld    (pc_ld),
        .mar_ld   (mar_ld),
        .acc_ld   (acc_ld),
        .out_ld   (out_ld),
        .acc_src  (acc_src),
        .alu_op   (alu_op),
        .retire   (retire),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s op=%h got=%b exp=%b t=%0t", tag, ir_op, got, exp, $time);
        end
    endtask

    // One clock cycle: drive ack at the falling edge, check just after.
    task automatic cyc(input string tag, input logic ack, input logic [14:0] exp);
        @(negedge clk);
        mem_ack = ack;
        #1;
        check_eq(tag, obs, exp);
    endtask

    // A memory transfer: w wait cycles (random 0..2 if w<0), then the ack cycle.
    task automatic access(input string tag, input int w, input logic [14:0] base,
                          input logic [14:0] done);
        int n;
        n = (w < 0) ? int'($urandom_range(0, 2)) : w;
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, base);
        cyc(tag, 1'b1, base | done);
    endtask

    function automatic logic [14:0] exec_exp(input logic [3:0] op, input logic z);
        case (op)
            4'h1:    return ACC | SRC1 | RET;
            4'h6:    return ACC | SRC3 | RET;
            4'h7:    return OUTL | RET;
            4'h8:    return PLD | RET;
            4'h9:    return z ? (PLD | RET) : RET;
            default: return RET;
        endcase
    endfunction

    task automatic run_instr(input logic [3:0] op, input logic z, input int w);
        logic [14:0] dec;
        // IR still holds the previous opcode during fetch; outputs must not care.
        ir_op = 4'($urandom);
        zero  = 1'($urandom);
        access("fetch", w, REQ, IRL | PINC);
        ir_op = op;
        zero  = z;
        if (op == 4'hF)                     dec = RET;
        else if (op >= 4'hA && op <= 4'hE)  dec = ILL;
        else                                dec = 15'h0000;
        cyc("decode", 1'($urandom), dec);
        if (op == 4'hF) begin
            for (int i = 0; i < 10; i++) cyc("halt", 1'(i % 2), HLT);
        end else begin
            if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9})
                access("opfetch", w, REQ, MAR | PINC);
            case (op)
                4'h2: access("memrd_lda", w, REQ | AS, ACC | RET);
                4'h4: access("memrd_add", w, REQ | AS, ACC | SRC2 | RET);
                4'h5: access("memrd_sub", w, REQ | AS, ACC | SRC2 | ALUS | RET);
                4'h3: access("memwr", w, REQ | WE | AS, RET);
                default: cyc("exec", 1'($urandom), exec_exp(op, z));
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb  = 1'b0;
        mem_ack = 1'b1;
        #1;
        check_eq("reset", obs, 15'h0000);
        @(negedge clk);
        #1;
        check_eq("reset_hold", obs, 15'h0000);
        resetb  = 1'b1;
        mem_ack = 1'b0;
        #1;
        check_eq("reset_release", obs, REQ);
    endtask

    initial begin
        resetb  = 1'b0;
        mem_ack = 1'b1;
        ir_op   = 4'h0;
        zero    = 1'b0;
        do_reset();

        // Directed cases.
        run_instr(4'h1, 1'b0, 0);   // LDI, zero wait
        run_instr(4'h3, 1'b0, 2);   // STA, two waits
        run_instr(4'h9, 1'b0, 0);   // JZ not taken
        run_instr(4'h9, 1'b1, 1);   // JZ taken
        run_instr(4'hB, 1'b0, 0);   // undefined opcode
        run_instr(4'h5, 1'b1, 0);   // SUB
        run_instr(4'h0, 1'b0, 0);   // NOP

        // Randomized instruction stream (HLT excluded).
        for (int k = 0; k < 80; k++)
            run_instr(4'($urandom_range(0, 14)), 1'($urandom), -1);

        // Reset asserted in the middle of a waiting STA write.
        ir_op = 4'h3;
        access("fetch", 0, REQ, IRL | PINC);
        cyc("decode", 1'b0, 15'h0000);
        access("opfetch", 0, REQ, MAR | PINC);
        cyc("memwr_wait", 1'b0, REQ | WE | AS);
        #1;
        resetb  = 1'b0;
        mem_ack = 1'b1;
        #1;
        check_eq("reset_mid", obs, 15'h0000);
        @(negedge clk);
        #1;
        check_eq("reset_mid_hold", obs, 15'h0000);
        resetb  = 1'b1;
        mem_ack = 1'b0;
        #1;
        check_eq("reset_mid_release", obs, REQ);
        run_instr(4'h2, 1'b0, -1);

        // HLT, then recovery through reset.
        run_instr(4'hF, 1'b0, 0);
        do_reset();
        run_instr(4'h7, 1'b0, 0);
        run_instr(4'h6, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcu_ctrl.md
# mcu_ctrl

Multi-cycle control unit for the 8-bit CISC MCU core (`mcu`). It sequences instruction fetch, operand fetch, memory access, execute and write-back over a single shared memory port, and drives every load/select strobe of the datapath (PC, IR, MAR, ACC, output latch). It holds no datapath registers itself, only the sequencing FSM and the decode logic.

## Interface
- No parameters (ISA width fixed at 8 bits, 4-bit opcode field).
- `clk` input 1: system clock, rising edge.
- `resetb` input 1: asynchronous active-low reset.
- `ir_op` input 4: `IR[7:4]`, current opcode.
- `zero` input 1: ACC==0 flag from datapath.
- `mem_ack` input 1: memory handshake acknowledge.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: write (1) / read (0), valid with `mem_req`.
- `addr_sel` output 1: memory address source, 0=PC, 1=MAR.
- `ir_ld`, `pc_inc`, `pc_ld`, `mar_ld`, `acc_ld`, `out_ld` output 1 each: single-cycle datapath strobes.
- `acc_src` output 2: 0=memory data, 1=MAR (immediate), 2=ALU, 3=`wordin`.
- `alu_op` output 1: 0=add, 1=sub.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `halted` output 1: high in HALT.
- `illegal` output 1: one-cycle pulse on decode of an undefined opcode.

## Operation
- Opcodes: 0 NOP, 1 LDI imm, 2 LDA a, 3 STA a, 4 ADD a, 5 SUB a, 6 IN, 7 OUT, 8 JMP a, 9 JZ a, F HLT; A–E undefined (execute as NOP, pulse `illegal`).
- 2-byte instructions: 1–5, 8, 9. Others are 1 byte.
- States: FETCH, DECODE, OPFETCH, EXEC, MEMRD, MEMWR, HALT.
- FETCH: `mem_req`=1, `addr_sel`=0; on `mem_ack`: `ir_ld`, `pc_inc` -> DECODE.
- DECODE: 2-byte -> OPFETCH; HLT -> HALT; else -> EXEC.
- OPFETCH: `mem_req`, `addr_sel`=0; on ack: `mar_ld`, `pc_inc`; LDA/ADD/SUB -> MEMRD, STA -> MEMWR, others -> EXEC.
- EXEC: LDI `acc_ld` src=1; IN `acc_ld` src=3; OUT `out_ld`; JMP `pc_ld`; JZ `pc_ld` only if `zero`; NOP/undefined nothing. `retire` -> FETCH.
- MEMRD: `mem_req`, `addr_sel`=1; on ack `acc_ld` (LDA src=0; ADD/SUB src=2, `alu_op` per opcode), `retire` -> FETCH.
- MEMWR: `mem_req`, `mem_we`, `addr_sel`=1; on ack `retire` -> FETCH.
- HALT: all strobes 0, `halted`=1; exit only via reset. `retire` pulses on entry (DECODE of HLT).

## Timing
- Strobes are combinational from state, `ir_op`, `zero`, `mem_ack`; state register only is sequential.
- Reset: state=FETCH; while `resetb`=0 every output forced 0. First `mem_req` in the first cycle after release.
- Handshake: `mem_req`, `mem_we`, `addr_sel` held stable until the cycle `mem_ack`=1; transfer completes in that cycle. `mem_ack` outside a requesting state is ignored. Zero-wait memory acks in the same cycle as the request.
- Zero-wait cycle counts: NOP/IN/OUT/undefined 3; LDI/JMP/JZ 4; LDA/ADD/SUB/STA 4; HLT 2 to HALT. Each wait cycle adds one.
- `zero` sampled in EXEC of JZ (reflects ACC after previous instruction).
- Reset asserted mid-access: FSM returns to FETCH immediately, `mem_req` drops asynchronously; no partial strobe.

## Structure
- Package `mcu_pkg`: opcode enum (4-bit), state enum, `acc_src` encodings, `alu_op` encodings, `is_two_byte()` function.
- One natural sub-module: `mcu_ctrl_decode` (combinational opcode class decode: two-byte, memory-read, memory-write, legal). FSM stays in `mcu_ctrl`.

## Test plan
- Reset: `resetb`=0 with `mem_ack`=1 -> all outputs 0; release -> next cycle FETCH, `mem_req`=1, `addr_sel`=0.
- LDI 0x1, zero-wait -> `ir_ld`+`pc_inc` cycle 1, `mar_ld`+`pc_inc` cycle 3, `acc_ld` src=1 and `retire` cycle 4.
- STA with 2 wait cycles in MEMWR -> `mem_req`,`mem_we`,`addr_sel`=1 stable 3 cycles; `retire` only on the ack cycle.
- JZ with `zero`=0 then `zero`=1 -> `pc_ld` absent, then asserted in EXEC; both `retire`.
- Opcode 0xB -> `illegal` pulse in DECODE, EXEC with no strobes, back to FETCH in 3 cycles.
- HLT then `mem_ack` toggling 10 cycles -> `halted`=1, no `mem_req`; `resetb` pulse -> FETCH resumes.
